// File: rtl/dmi_link_buffer.sv
// Credit-managed DMI request/response buffer between the JTAG DTM and the Debug Module.
// Optional DM response watchdog is compiled in with `define DMI_TIMEOUT_EN.
module dmi_link_buffer #(
  parameter int ReqDepth       = 4,
  parameter int RespDepth      = 4,
  parameter int MaxOutstanding = 4,
  parameter int TimeoutCycles  = 1024
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                dmi_clear_ni,
  input  logic [40:0]                         up_req_i,
  input  logic                                up_req_valid_i,
  output logic                                up_req_ready_o,
  output logic [33:0]                         up_resp_o,
  output logic                                up_resp_valid_o,
  input  logic                                up_resp_ready_i,
  output logic [40:0]                         dn_req_o,
  output logic                                dn_req_valid_o,
  input  logic                                dn_req_ready_i,
  input  logic [33:0]                         dn_resp_i,
  input  logic                                dn_resp_valid_i,
  output logic                                dn_resp_ready_o,
  output logic [$clog2(MaxOutstanding+1)-1:0] inflight_o,
  output logic                                timeout_o
);

  localparam int RAW = $clog2(ReqDepth);
  localparam int PAW = $clog2(RespDepth);
  localparam int IW  = $clog2(MaxOutstanding + 1);

  if (MaxOutstanding > RespDepth || ReqDepth < 2 || RespDepth < 2 || TimeoutCycles < 2) begin : g_bad_params
    $error("dmi_link_buffer: invalid parameter set");
  end

  logic [40:0]   req_mem  [ReqDepth];
  logic [33:0]   resp_mem [RespDepth];
  logic [RAW:0]  req_wp, req_rp;
  logic [PAW:0]  resp_wp, resp_rp;
  logic [IW-1:0] inflight, dn_pending, drop_cnt;
  logic          req_empty, req_full, resp_empty, resp_full;
  logic          up_req_fire, up_resp_fire, dn_req_fire, dn_resp_fire;
  logic          resp_keep, pend_ret, resp_push, timeout_fire;
  logic [33:0]   resp_wdata;

  // Every port pair uses valid/ready: a beat moves on a clk edge where both are 1;
  // a raised valid holds with stable data until ready. Ready never depends on the peer's valid.
  assign req_empty  = (req_wp == req_rp);
  assign req_full   = (req_wp[RAW] != req_rp[RAW]) && (req_wp[RAW-1:0] == req_rp[RAW-1:0]);
  assign resp_empty = (resp_wp == resp_rp);
  assign resp_full  = (resp_wp[PAW] != resp_rp[PAW]) && (resp_wp[PAW-1:0] == resp_rp[PAW-1:0]);

  assign up_req_ready_o  = dmi_clear_ni && !req_full && (inflight < IW'(MaxOutstanding));
  assign dn_req_valid_o  = dmi_clear_ni && !req_empty;
  assign up_resp_valid_o = dmi_clear_ni && !resp_empty;
  assign dn_resp_ready_o = (drop_cnt != '0) || !resp_full;
  assign dn_req_o        = req_empty  ? '0 : req_mem[req_rp[RAW-1:0]];
  assign up_resp_o       = resp_empty ? '0 : resp_mem[resp_rp[PAW-1:0]];
  assign inflight_o      = inflight;

  assign up_req_fire  = up_req_valid_i && up_req_ready_o;
  assign dn_req_fire  = dn_req_valid_o && dn_req_ready_i;
  assign dn_resp_fire = dn_resp_valid_i && dn_resp_ready_o;
  assign up_resp_fire = up_resp_valid_o && up_resp_ready_i;

  // Responses arriving while drop_cnt is non-zero belong to ops abandoned by a flush or timeout.
  assign resp_keep  = dn_resp_fire && (drop_cnt == '0);
  assign pend_ret   = resp_keep && (dn_pending != '0);
  assign resp_push  = dmi_clear_ni && (resp_keep || timeout_fire);
  assign resp_wdata = timeout_fire ? {32'h0, 2'h2} : dn_resp_i;

`ifdef DMI_TIMEOUT_EN
  localparam int WW = $clog2(TimeoutCycles);
  logic [WW-1:0] wdog;
  logic          wdog_run;
  logic          timeout_q;

  assign wdog_run     = (dn_pending != '0) && (drop_cnt == '0);
  // A real response in the expiry cycle wins over the synthetic error.
  assign timeout_fire = dmi_clear_ni && wdog_run && !dn_resp_fire && (wdog == WW'(TimeoutCycles - 1));
  assign timeout_o    = timeout_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !dmi_clear_ni) begin
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_fire;
      if (dn_resp_fire || timeout_fire || !wdog_run) wdog <= '0;
      else                                           wdog <= wdog + WW'(1);
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (up_req_fire) req_mem[req_wp[RAW-1:0]]   <= up_req_i;
    if (resp_push)   resp_mem[resp_wp[PAW-1:0]] <= resp_wdata;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_wp     <= '0;
      req_rp     <= '0;
      resp_wp    <= '0;
      resp_rp    <= '0;
      inflight   <= '0;
      dn_pending <= '0;
      drop_cnt   <= '0;
    end else if (!dmi_clear_ni) begin
      req_wp     <= '0;
      req_rp     <= '0;
      resp_wp    <= '0;
      resp_rp    <= '0;
      inflight   <= '0;
      dn_pending <= '0;
      drop_cnt   <= dn_pending - IW'(pend_ret);
    end else begin
      if (up_req_fire)  req_wp  <= req_wp + (RAW+1)'(1);
      if (dn_req_fire)  req_rp  <= req_rp + (RAW+1)'(1);
      if (resp_push)    resp_wp <= resp_wp + (PAW+1)'(1);
      if (up_resp_fire) resp_rp <= resp_rp + (PAW+1)'(1);
      inflight   <= inflight + IW'(up_req_fire) - IW'(up_resp_fire);
      dn_pending <= dn_pending + IW'(dn_req_fire) - IW'(pend_ret) - IW'(timeout_fire);
      if (dn_resp_fire && drop_cnt != '0) drop_cnt <= drop_cnt - IW'(1);
      else if (timeout_fire)              drop_cnt <= drop_cnt + IW'(1);
    end
  end

endmodule
